// File: rtl/scan_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
package scan_pkg;

  localparam int NIB_W      = 4;
  localparam int MAX_DIGITS = 8;

  // Widest anode vector; callers truncate to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] adrive_off();
    return '1;
  endfunction

  // Phase 0 of every slot is the anti-ghosting guard; phases 1..level are lit.
  function automatic logic phase_on(input logic [7:0] phase, input logic [7:0] level);
    return (phase != 8'd0) && (phase <= level);
  endfunction

endpackage

// File: rtl/scan_lzb_mask.sv
// Leading-zero suppression mask: digit i (i >= 1) is masked when it and every higher nibble are zero.
module scan_lzb_mask
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NIB_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]       mask
);

  logic hi_zero;

  always_comb begin
    mask    = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero & (digits[NIB_W*i +: NIB_W] == '0);
      mask[i] = hi_zero;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input snapshot.
// Optional leading-zero blanking is compiled in when SCAN_LZB_EN is defined.
module digit_scan_mux
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_BITS   = 18,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NIB_W*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [BRIGHT_BITS-1:0]        bright,
  output logic [NIB_W-1:0]              muxd,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         adrive,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_start
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [SEL_W-1:0]      LAST_IDX   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ADRIVE_OFF = NUM_DIGITS'(adrive_off());

  logic [TICK_BITS-1:0]          tcnt;
  logic [SEL_W-1:0]              idx;
  logic                          frame_hit;

  logic [NIB_W*NUM_DIGITS-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]         snap_blank;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic [BRIGHT_BITS-1:0]        snap_bright;

  logic [BRIGHT_BITS-1:0]        phase;
  logic                          slot_on;
  logic [NUM_DIGITS-1:0]         supp;
  logic [NUM_DIGITS-1:0]         drive_next;
  logic [NIB_W-1:0]              cur_digit;
  logic                          cur_dp;
  logic                          lit;

  // Stage p0: slot/phase counters; idx skips unused codes for non-power-of-two counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      idx  <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == '1)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign frame_hit = (idx == '0) && (tcnt == '0);

  // Snapshot: loaded once per frame; blank powers up set so nothing lights before the first load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_digits <= '0;
      snap_blank  <= '1;
      snap_dp     <= '0;
      snap_bright <= '0;
    end else if (frame_hit) begin
      snap_digits <= digits;
      snap_blank  <= blank;
      snap_dp     <= dp;
      snap_bright <= bright;
    end
  end

`ifdef SCAN_LZB_EN
  scan_lzb_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lzb (
    .digits(snap_digits),
    .mask  (supp)
  );
`else
  assign supp = '0;
`endif

  assign phase   = tcnt[TICK_BITS-1 -: BRIGHT_BITS];
  assign slot_on = phase_on(8'(phase), 8'(snap_bright));

  always_comb begin
    drive_next = ADRIVE_OFF;
    cur_digit  = '0;
    cur_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == SEL_W'(i)) begin
        cur_digit     = snap_digits[NIB_W*i +: NIB_W];
        cur_dp        = snap_dp[i];
        drive_next[i] = ~(slot_on & ~snap_blank[i] & ~supp[i]);
      end
    end
  end

  assign lit = ~&drive_next;

  // Stage p1: registered display outputs, one clock behind the counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adrive      <= ADRIVE_OFF;
      muxd        <= '0;
      dp_n        <= 1'b1;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      adrive      <= drive_next;
      muxd        <= cur_digit;
      dp_n        <= ~(cur_dp & lit);
      digit_sel   <= idx;
      frame_start <= frame_hit;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with 3 digits, 16-clock slots and 2-bit brightness.
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] digits;
  logic [2:0]  blank;
  logic [2:0]  dp;
  logic [1:0]  bright;
  logic [3:0]  muxd;
  logic        dp_n;
  logic [2:0]  adrive;
  logic [1:0]  digit_sel;
  logic        frame_start;

  int compared   = 0;
  int mismatched = 0;

  digit_scan_mux #(
    .NUM_DIGITS (3),
    .TICK_BITS  (4),
    .BRIGHT_BITS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .blank      (blank),
    .dp         (dp),
    .bright     (bright),
    .muxd       (muxd),
    .dp_n       (dp_n),
    .adrive     (adrive),
    .digit_sel  (digit_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " adrive"},      16'(adrive),      16'h7);
    chk({tag, " muxd"},        16'(muxd),        16'h0);
    chk({tag, " dp_n"},        16'(dp_n),        16'h1);
    chk({tag, " digit_sel"},   16'(digit_sel),   16'h0);
    chk({tag, " frame_start"}, 16'(frame_start), 16'h0);
  endtask

  // Waits for frame_start, then checks every cycle of one frame against the expected snapshot.
  task automatic run_frame(input string name, input logic [11:0] dg, input logic [1:0] b,
                           input logic [2:0] bl, input logic [2:0] dpv,
                           input bit mid_chg, input logic [11:0] mid_dg);
    bit         found;
    bit         hz;
    logic [2:0] sp;
    logic [2:0] exp_a;
    int         s, t, ph;
    bit         on, lit;
    found = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, " frame_start seen"}, 16'(found), 16'h1);
    if (!found) return;
    chk({name, " k0 adrive"}, 16'(adrive), 16'h7);
    chk({name, " k0 digit_sel"}, 16'(digit_sel), 16'h0);
    sp = 3'b000;
`ifdef SCAN_LZB_EN
    hz = 1'b1;
    for (int i = 2; i >= 1; i--) begin
      hz = hz && (dg[4*i +: 4] == 4'h0);
      sp[i] = hz;
    end
`else
    hz = 1'b0;
`endif
    for (int k = 1; k < 48; k++) begin
      @(negedge clk);
      if (mid_chg && k == 20) digits = mid_dg;
      s     = k / 16;
      t     = k % 16;
      ph    = t / 4;
      on    = (ph >= 1) && (ph <= int'(b));
      lit   = on && !bl[s] && !sp[s];
      exp_a = 3'b111;
      if (lit) exp_a[s] = 1'b0;
      chk($sformatf("%s k%0d adrive", name, k),      16'(adrive),      16'(exp_a));
      chk($sformatf("%s k%0d muxd", name, k),        16'(muxd),        16'(dg[4*s +: 4]));
      chk($sformatf("%s k%0d dp_n", name, k),        16'(dp_n),        16'(!(dpv[s] && lit)));
      chk($sformatf("%s k%0d digit_sel", name, k),   16'(digit_sel),   16'(s));
      chk($sformatf("%s k%0d frame_start", name, k), 16'(frame_start), 16'h0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    digits = 12'h321;
    blank  = 3'b000;
    dp     = 3'b000;
    bright = 2'd3;
    #3;
    chk_reset_values("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_frame("full", 12'h321, 2'd3, 3'b000, 3'b000, 1'b0, 12'h0);
    bright = 2'd1;
    run_frame("dim1", 12'h321, 2'd1, 3'b000, 3'b000, 1'b0, 12'h0);
    bright = 2'd0;
    run_frame("off", 12'h321, 2'd0, 3'b000, 3'b000, 1'b0, 12'h0);
    bright = 2'd3;
    blank  = 3'b010;
    dp     = 3'b001;
    run_frame("blank_dp", 12'h321, 2'd3, 3'b010, 3'b001, 1'b0, 12'h0);
    blank = 3'b000;
    dp    = 3'b000;
    run_frame("mid_old", 12'h321, 2'd3, 3'b000, 3'b000, 1'b1, 12'h654);
    run_frame("mid_new", 12'h654, 2'd3, 3'b000, 3'b000, 1'b0, 12'h0);
    digits = 12'h005;
    run_frame("lz005", 12'h005, 2'd3, 3'b000, 3'b000, 1'b0, 12'h0);
    digits = 12'h000;
    run_frame("lz000", 12'h000, 2'd3, 3'b000, 3'b000, 1'b0, 12'h0);

    repeat (21) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_values("midslot_reset");
    @(negedge clk);
    reset  = 1'b0;
    digits = 12'h321;
    bright = 2'd2;
    run_frame("restart", 12'h321, 2'd2, 3'b000, 3'b000, 1'b0, 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
